// File: rtl/apsk_metric_pkg.sv
// Shared definitions for the APSK metric engine: mode encoding, Q-format
// widths, metric saturation value and the erased-point marker.
package apsk_metric_pkg;

  typedef enum logic [1:0] {
    MODE_4   = 2'd0,
    MODE_16  = 2'd1,
    MODE_32  = 2'd2,
    MODE_64  = 2'd3
  } apsk_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } eng_state_e;

  localparam int unsigned Q_WORDLENGTH = 18;
  localparam int unsigned Q_FRACTION   = 10;

  // Largest positive value of a signed word of width wl.
  function automatic int unsigned max_metric_of(input int unsigned wl);
    return (32'd1 << (wl - 1)) - 32'd1;
  endfunction

  localparam int unsigned MAX_METRIC = max_metric_of(Q_WORDLENGTH);

  // A point with both components all-ones marks an erased constellation entry.
  localparam logic ERASURE_BIT = 1'b1;

  function automatic logic [7:0] nsym_of(input logic [1:0] mode);
    logic [7:0] n;
    case (apsk_mode_e'(mode))
      MODE_4:  n = 8'd4;
      MODE_16: n = 8'd16;
      MODE_32: n = 8'd32;
      default: n = 8'd64;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/apsk_metric_lane.sv
// One metric lane: |u - h*s|^2 with saturation, two register stages gated by en.
module apsk_metric_lane
  import apsk_metric_pkg::*;
#(
  parameter int unsigned WORDLENGTH = Q_WORDLENGTH,
  parameter int unsigned FRACTION   = Q_FRACTION
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [WORDLENGTH-1:0] u_re,
  input  logic [WORDLENGTH-1:0] u_im,
  input  logic [WORDLENGTH-1:0] h,
  input  logic [WORDLENGTH-1:0] s_re,
  input  logic [WORDLENGTH-1:0] s_im,
  output logic [WORDLENGTH-1:0] metric
);

  localparam int unsigned W = WORDLENGTH;
  localparam logic [W-1:0] MAXM  = W'(max_metric_of(W));
  localparam logic [W-1:0] ERASE = {W{ERASURE_BIT}};

  logic [2*W-1:0] prod_re, prod_im;
  logic [W-1:0]   hs_re, hs_im;
  logic [W:0]     d_re, d_im, d_re_q, d_im_q;
  logic           erase_d, erase_q1, erase_q2;
  logic [2*W+1:0] sqf_re, sqf_im, sqs_re, sqs_im;
  logic [W-2:0]   sq_re, sq_im, sq_re_q, sq_im_q;
  logic [W-1:0]   sum;
  logic           unused_prod;

  // Scale the point by h and form the W+1 bit difference; sign-extended
  // unsigned products keep the low 2W bits exact without signed casts.
  always_comb begin
    prod_re = {{W{h[W-1]}}, h} * {{W{s_re[W-1]}}, s_re};
    prod_im = {{W{h[W-1]}}, h} * {{W{s_im[W-1]}}, s_im};
    hs_re   = prod_re[FRACTION +: W];
    hs_im   = prod_im[FRACTION +: W];
    d_re    = {u_re[W-1], u_re} - {hs_re[W-1], hs_re};
    d_im    = {u_im[W-1], u_im} - {hs_im[W-1], hs_im};
    erase_d = (s_re == ERASE) && (s_im == ERASE);
    unused_prod = ^{prod_re[2*W-1:FRACTION+W], prod_re[FRACTION-1:0],
                    prod_im[2*W-1:FRACTION+W], prod_im[FRACTION-1:0]};
  end

  // P1: register the differences and the erasure flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_re_q   <= '0;
      d_im_q   <= '0;
      erase_q1 <= 1'b0;
    end else if (en) begin
      d_re_q   <= d_re;
      d_im_q   <= d_im;
      erase_q1 <= erase_d;
    end
  end

  // Square, rescale and clamp each component to the metric range.
  always_comb begin
    sqf_re = {{(W+1){d_re_q[W]}}, d_re_q} * {{(W+1){d_re_q[W]}}, d_re_q};
    sqf_im = {{(W+1){d_im_q[W]}}, d_im_q} * {{(W+1){d_im_q[W]}}, d_im_q};
    sqs_re = sqf_re >> FRACTION;
    sqs_im = sqf_im >> FRACTION;
    sq_re  = (|sqs_re[2*W+1:W-1]) ? '1 : sqs_re[W-2:0];
    sq_im  = (|sqs_im[2*W+1:W-1]) ? '1 : sqs_im[W-2:0];
  end

  // P2: register the clamped squares.
  always_ff @(posedge clk) begin
    if (rst) begin
      sq_re_q  <= '0;
      sq_im_q  <= '0;
      erase_q2 <= 1'b0;
    end else if (en) begin
      sq_re_q  <= sq_re;
      sq_im_q  <= sq_im;
      erase_q2 <= erase_q1;
    end
  end

  // Sum of two clamped squares fits W bits; its MSB set means overflow.
  always_comb begin
    sum    = {1'b0, sq_re_q} + {1'b0, sq_im_q};
    metric = (erase_q2 || sum[W-1]) ? MAXM : sum;
  end

endmodule

// File: rtl/apsk_metric_engine.sv
// Time-multiplexed APSK metric engine: issues constellation groups from a LUT,
// runs them through LANES metric lanes and presents them with valid/ready.
module apsk_metric_engine
  import apsk_metric_pkg::*;
#(
  parameter int unsigned WORDLENGTH = Q_WORDLENGTH,
  parameter int unsigned FRACTION   = Q_FRACTION,
  parameter int unsigned MAX_SYM    = 64,
  parameter int unsigned LANES      = 8,
  localparam int unsigned NGMAX     = MAX_SYM / LANES,
  localparam int unsigned GW        = (NGMAX > 1) ? $clog2(NGMAX) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WORDLENGTH-1:0]       u_re,
  input  logic [WORDLENGTH-1:0]       u_im,
  input  logic [WORDLENGTH-1:0]       h,
  input  logic [1:0]                  mode,
  output logic [GW-1:0]               lut_addr,
  input  logic [LANES*WORDLENGTH-1:0] lut_re,
  input  logic [LANES*WORDLENGTH-1:0] lut_im,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*WORDLENGTH-1:0] out_metric,
  output logic [GW-1:0]               out_group,
  output logic [LANES-1:0]            out_lane_mask,
  output logic                        out_last
);

  localparam int unsigned W = WORDLENGTH;
  localparam logic [W-1:0] MAXM = W'(max_metric_of(W));

  eng_state_e state_q, state_d;
  logic [GW-1:0] g_q, g_d, last_g_q, last_g_sel;
  logic [7:0]    nsym_q, nsym_sel;
  logic [31:0]   ng_sel;
  logic [W-1:0]  u_re_q, u_im_q, h_q;
  logic          stall, issue, load, issue_last;
  logic [LANES-1:0] issue_mask;

  logic             v1, v2, l1, l2;
  logic [LANES-1:0] m1, m2;
  logic [GW-1:0]    g1, g2;
  logic [W-1:0]     lane_metric [LANES];
  logic [LANES*W-1:0] metric_next;

  assign stall    = out_valid && !out_ready;
  assign lut_addr = g_q;

  // Symbol and group count for the mode presented at the input.
  always_comb begin
    nsym_sel = nsym_of(mode);
    if (32'(nsym_sel) > MAX_SYM) nsym_sel = 8'(MAX_SYM);
    ng_sel     = (32'(nsym_sel) + LANES - 32'd1) / LANES;
    last_g_sel = GW'(ng_sel - 32'd1);
  end

  // FSM next state, group counter and handshake; the final issue cycle
  // doubles as the acceptance slot so samples run back-to-back.
  always_comb begin
    state_d  = state_q;
    g_d      = g_q;
    in_ready = 1'b0;
    issue    = 1'b0;
    load     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          g_d     = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!stall) begin
          issue = 1'b1;
          if (g_q == last_g_q) begin
            in_ready = 1'b1;
            g_d      = '0;
            if (in_valid) load = 1'b1;
            else          state_d = ST_IDLE;
          end else begin
            g_d = g_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Lane occupancy and last flag for the group being issued.
  always_comb begin
    issue_mask = '0;
    for (int unsigned k = 0; k < LANES; k++)
      issue_mask[k] = issue && ((32'(g_q) * LANES + k) < 32'(nsym_q));
    issue_last = issue && (g_q == last_g_q);
  end

  // FSM state and group counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      g_q     <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
    end
  end

  // Latched sample and per-sample geometry, loaded on an accepting handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      u_re_q   <= '0;
      u_im_q   <= '0;
      h_q      <= '0;
      nsym_q   <= '0;
      last_g_q <= '0;
    end else if (load) begin
      u_re_q   <= u_re;
      u_im_q   <= u_im;
      h_q      <= h;
      nsym_q   <= nsym_sel;
      last_g_q <= last_g_sel;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    apsk_metric_lane #(
      .WORDLENGTH(WORDLENGTH),
      .FRACTION  (FRACTION)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .en    (!stall),
      .u_re  (u_re_q),
      .u_im  (u_im_q),
      .h     (h_q),
      .s_re  (lut_re[k*W +: W]),
      .s_im  (lut_im[k*W +: W]),
      .metric(lane_metric[k])
    );
  end

  // Sideband pipeline matching the two lane stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0; v2 <= 1'b0;
      l1 <= 1'b0; l2 <= 1'b0;
      m1 <= '0;   m2 <= '0;
      g1 <= '0;   g2 <= '0;
    end else if (!stall) begin
      v1 <= issue;
      l1 <= issue_last;
      m1 <= issue_mask;
      g1 <= issue ? g_q : '0;
      v2 <= v1;
      l2 <= l1;
      m2 <= m1;
      g2 <= g1;
    end
  end

  // Unused lanes report the saturation value; bubbles carry zeros.
  always_comb begin
    metric_next = '0;
    for (int unsigned k = 0; k < LANES; k++)
      metric_next[k*W +: W] = !v2 ? '0 : (m2[k] ? lane_metric[k] : MAXM);
  end

  // Output register, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_metric    <= '0;
      out_group     <= '0;
      out_lane_mask <= '0;
      out_last      <= 1'b0;
    end else if (!stall) begin
      out_valid     <= v2;
      out_metric    <= metric_next;
      out_group     <= g2;
      out_lane_mask <= m2;
      out_last      <= l2;
    end
  end

endmodule

// File: tb/tb_apsk_metric_engine.sv
// Directed bench for apsk_metric_engine with hand-computed expected metrics.
module tb_apsk_metric_engine;

  localparam int unsigned W = 18;
  localparam int unsigned L = 8;

  logic           clk = 1'b0;
  logic           rst, in_valid, in_ready, out_valid, out_ready, out_last;
  logic [W-1:0]   u_re, u_im, h;
  logic [1:0]     mode;
  logic [2:0]     lut_addr, out_group;
  logic [L*W-1:0] lut_re, lut_im, out_metric;
  logic [L-1:0]   out_lane_mask;
  logic [W-1:0]   mre [64];
  logic [W-1:0]   mim [64];
  int             total = 0;
  int             bad = 0;

  always #5 clk = ~clk;

  apsk_metric_engine #(
    .WORDLENGTH(18),
    .FRACTION  (10),
    .MAX_SYM   (64),
    .LANES     (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .u_re         (u_re),
    .u_im         (u_im),
    .h            (h),
    .mode         (mode),
    .lut_addr     (lut_addr),
    .lut_re       (lut_re),
    .lut_im       (lut_im),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_metric   (out_metric),
    .out_group    (out_group),
    .out_lane_mask(out_lane_mask),
    .out_last     (out_last)
  );

  // Combinational constellation LUT.
  always_comb begin
    lut_re = '0;
    lut_im = '0;
    for (int unsigned k = 0; k < L; k++) begin
      lut_re[k*W +: W] = mre[32'(lut_addr) * L + k];
      lut_im[k*W +: W] = mim[32'(lut_addr) * L + k];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lane(input int unsigned k);
    return 32'(out_metric[k*W +: W]);
  endfunction

  task automatic lut_zero();
    for (int unsigned p = 0; p < 64; p++) begin
      mre[p] = '0;
      mim[p] = '0;
    end
  endtask

  // Point p = (32p, 0): with u=0, h=1024 the metric is p^2.
  task automatic lut_square();
    for (int unsigned p = 0; p < 64; p++) begin
      mre[p] = 18'(32 * p);
      mim[p] = '0;
    end
  endtask

  task automatic drive(input logic [1:0] m, input int ure, input int uim, input int hh);
    mode = m;
    u_re = 18'(ure);
    u_im = 18'(uim);
    h    = 18'(hh);
  endtask

  task automatic wait_out(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    check(tag, 32'(out_valid), 32'd1);
  endtask

  initial begin
    int exp_g;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    drive(2'd0, 0, 0, 0);
    lut_zero();
    repeat (3) step();
    rst = 1'b0;

    // Reset state
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_metric", lane(0), 32'd0);
    check("rst_mask", 32'(out_lane_mask), 32'd0);
    check("rst_addr", 32'(lut_addr), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);

    // Basic metrics, mode 3, exact latency
    lut_zero();
    mre[0] = 18'd1024; mre[2] = 18'h3FC00; mim[9] = 18'd1024; mre[63] = 18'd3072;
    drive(2'd3, 1024, 0, 1024);
    in_valid = 1'b1;
    check("t1_acc_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c < 8) begin
        check("t1_addr", 32'(lut_addr), 32'(c));
        check("t1_ready", 32'(in_ready), 32'(c == 7));
      end
      if (c >= 3 && c <= 10) begin
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_group", 32'(out_group), 32'(c - 3));
        check("t1_last", 32'(out_last), 32'(c == 10));
        check("t1_mask", 32'(out_lane_mask), 32'hFF);
      end else begin
        check("t1_bubble", 32'(out_valid), 32'd0);
      end
      if (c == 3) begin
        check("t1_m0", lane(0), 32'd0);
        check("t1_m1", lane(1), 32'd1024);
        check("t1_m2", lane(2), 32'd4096);
        check("t1_m3", lane(3), 32'd1024);
      end
      if (c == 4) begin
        check("t1_g1m0", lane(0), 32'd1024);
        check("t1_g1m1", lane(1), 32'd2048);
      end
      if (c == 10) check("t1_g7m7", lane(7), 32'd4096);
      step();
    end

    // Saturation, mode 0
    lut_zero();
    mre[0] = 18'(-130048); mre[1] = 18'h3FFFF; mim[1] = 18'h3FFFF;
    mre[2] = 18'd130048; mre[3] = 18'd129024;
    drive(2'd0, 130048, 0, 1024);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_out("t2_wait");
    check("t2_sat", lane(0), 32'd131071);
    check("t2_m1", lane(1), 32'd131071);
    check("t2_m2", lane(2), 32'd0);
    check("t2_m3", lane(3), 32'd1024);
    check("t2_mask", 32'(out_lane_mask), 32'h0F);
    check("t2_last", 32'(out_last), 32'd1);
    step();
    check("t2_single", 32'(out_valid), 32'd0);

    // Erasure and unused lanes, mode 0
    lut_zero();
    mre[1] = 18'h3FFFF; mim[1] = 18'h3FFFF;
    mre[2] = 18'd1024; mim[2] = 18'd1024; mim[3] = 18'(-2048);
    drive(2'd0, 0, 0, 1024);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_out("t3_wait");
    check("t3_m0", lane(0), 32'd0);
    check("t3_erase", lane(1), 32'd131071);
    check("t3_m2", lane(2), 32'd2048);
    check("t3_m3", lane(3), 32'd4096);
    check("t3_unused4", lane(4), 32'd131071);
    check("t3_unused7", lane(7), 32'd131071);
    check("t3_mask", 32'(out_lane_mask), 32'h0F);
    check("t3_group", 32'(out_group), 32'd0);
    check("t3_last", 32'(out_last), 32'd1);
    step();

    // Backpressure mid-sample
    lut_square();
    drive(2'd3, 0, 0, 1024);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", 32'(out_valid), 32'd1);
      check("t4_hold_group", 32'(out_group), 32'd0);
      check("t4_hold_m7", lane(7), 32'd49);
      check("t4_hold_addr", 32'(lut_addr), 32'd3);
      check("t4_hold_ready", 32'(in_ready), 32'd0);
      step();
    end
    out_ready = 1'b1;
    exp_g = 0;
    for (int n = 0; n < 30 && exp_g < 8; n++) begin
      if (out_valid) begin
        check("t4_group", 32'(out_group), 32'(exp_g));
        check("t4_m0", lane(0), 32'(64 * exp_g * exp_g));
        check("t4_m7", lane(7), 32'((8 * exp_g + 7) * (8 * exp_g + 7)));
        check("t4_last", 32'(out_last), 32'(exp_g == 7));
        exp_g++;
      end
      step();
    end
    check("t4_count", 32'(exp_g), 32'd8);
    check("t4_after", 32'(out_valid), 32'd0);

    // Back-to-back samples: mode 3 then mode 0
    drive(2'd3, 0, 0, 1024);
    in_valid = 1'b1;
    check("t5_acc_ready", 32'(in_ready), 32'd1);
    step();
    drive(2'd0, 32, 0, 1024);
    for (int c = 0; c < 13; c++) begin
      if (c <= 7) check("t5_addr", 32'(lut_addr), 32'(c));
      if (c == 8) check("t5_addr_b", 32'(lut_addr), 32'd0);
      if (c <= 8) check("t5_ready", 32'(in_ready), 32'(c >= 7));
      if (c == 8) in_valid = 1'b0;
      if (c >= 3 && c <= 11) begin
        check("t5_valid", 32'(out_valid), 32'd1);
        check("t5_group", 32'(out_group), 32'((c <= 10) ? c - 3 : 0));
        check("t5_last", 32'(out_last), 32'(c >= 10));
      end else begin
        check("t5_bubble", 32'(out_valid), 32'd0);
      end
      if (c == 5) check("t5_g2m7", lane(7), 32'd529);
      if (c == 11) begin
        check("t5_b_m0", lane(0), 32'd1);
        check("t5_b_m1", lane(1), 32'd0);
        check("t5_b_m2", lane(2), 32'd1);
        check("t5_b_m3", lane(3), 32'd4);
        check("t5_b_m4", lane(4), 32'd131071);
        check("t5_b_mask", 32'(out_lane_mask), 32'h0F);
      end
      step();
    end

    // Reset during group 3
    drive(2'd3, 0, 0, 1024);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    check("t6_pre_addr", 32'(lut_addr), 32'd3);
    check("t6_pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_metric0", lane(0), 32'd0);
    check("t6_metric7", lane(7), 32'd0);
    check("t6_group", 32'(out_group), 32'd0);
    check("t6_ready", 32'(in_ready), 32'd1);
    check("t6_addr", 32'(lut_addr), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_flushed", 32'(out_valid), 32'd0);
    end
    drive(2'd0, 32, 0, 1024);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("t6_new_addr", 32'(lut_addr), 32'd0);
    repeat (3) step();
    check("t6_new_valid", 32'(out_valid), 32'd1);
    check("t6_new_group", 32'(out_group), 32'd0);
    check("t6_new_m0", lane(0), 32'd1);
    check("t6_new_m3", lane(3), 32'd4);
    check("t6_new_last", 32'(out_last), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apsk_metric_engine.md
# apsk_metric_engine

Time-multiplexed, pipelined Euclidean-metric engine for the multi-mode APSK exhaustive demapper. It accepts one equalised received sample `u` with channel gain `h` and a constellation mode. It then streams the metrics |u − h·s|² for every constellation point `s`, `LANES` points per cycle, reading points from an external constellation LUT by group address. It sits between the equaliser front end and the LLR min-search stage. It replaces the fixed 64-wide metric array with a parametrised lane count, mode-dependent symbol count, saturating arithmetic and valid/ready flow control.

## Interface
- `WORDLENGTH`, 18: Q(WORDLENGTH−FRACTION).FRACTION signed sample width.
- `FRACTION`, 10: fractional bits.
- `MAX_SYM`, 64: largest constellation size; power of two.
- `LANES`, 8: metrics per cycle; power of two, must divide `MAX_SYM`.
- `clk`, in, 1: clock; all logic is on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `in_valid`, in, 1: sample valid.
- `in_ready`, out, 1: engine accepts a sample this cycle.
- `u_re`, `u_im`, `h`, in, WORDLENGTH each: signed received sample and real channel gain.
- `mode`, in, 2: 0 = 4 points, 1 = 16, 2 = 32, 3 = 64. Must not select more than `MAX_SYM` points.
- `lut_addr`, out, log2(MAX_SYM/LANES) (min 1): group index. The LUT answers combinationally in the same cycle.
- `lut_re`, `lut_im`, in, LANES·WORDLENGTH: points `lut_addr·LANES + k` in lane k.
- `out_valid`, in from consumer `out_ready`, 1 each: output handshake.
- `out_metric`, out, LANES·WORDLENGTH: unsigned metrics, lane k is point `out_group·LANES + k`.
- `out_group`, out, log2(MAX_SYM/LANES) (min 1): group index of `out_metric`.
- `out_lane_mask`, out, LANES: 1 = lane holds a real point.
- `out_last`, out, 1: final group of the current sample.

## Operation
- **Symbol count.** NSYM = 4/16/32/64 by `mode`. The group count is NG = ceil(NSYM/LANES).
- **FSM IDLE.** `in_ready`=1. On `in_valid`&&`in_ready`, latch `u_re`, `u_im`, `h` and NG, clear the group counter, and go to RUN.
- **FSM RUN.** When not stalled, issue group g: drive `lut_addr`=g, sample the LUT, increment g.
  - On issue of g = NG−1, `in_ready`=1 in that same cycle.
  - An accepting handshake on that cycle restarts at g=0 with the new sample (back-to-back). Otherwise the FSM goes to IDLE.
- **Stall.** `stall` = `out_valid` && !`out_ready`. A stall freezes every pipeline stage, the group counter and the FSM. In RUN during a stall, `in_ready`=0.
- **Lane arithmetic** (per lane, saturating):
  - hs = bits [FRACTION+WORDLENGTH−1 : FRACTION] of the 2W-bit signed product h·s.
  - d = u − hs, computed at WORDLENGTH+1 bits, so it never wraps.
  - sq = (d·d) >> FRACTION, clamped to MAX_METRIC = 2^(WORDLENGTH−1)−1.
  - metric = min(sq_re + sq_im, MAX_METRIC).
- **Erasure.** A point with re and im both all-ones gives metric MAX_METRIC.
- **Unused lanes.** Lanes where `g·LANES + k` ≥ NSYM output MAX_METRIC with mask bit 0. Example: mode 0 with LANES=8 gives mask 0x0F.

## Timing
- Pipeline: issue (cycle t) → P1 register of hs, d inputs → P2 register of sq_re, sq_im → output register.
- Metrics for the group issued at t appear with `out_valid`=1 at t+3, absent stalls.
- Throughput is one group per cycle. A sample in mode 3 with LANES=8 occupies 8 issue cycles.
- `out_valid` holds, and all `out_*` stay stable, until `out_ready`. Bubbles are not collapsed.
- `rst` (any cycle, including mid-sample) takes effect at the next edge:
  - FSM goes to IDLE, valid bits clear, and the group counter and latched sample clear.
  - All `out_*` become 0, `lut_addr` 0, `in_ready` 1 on the cycle after reset deasserts.
  - In-flight groups are discarded and are not resumed.
- A `mode` change only takes effect at an accepting handshake.

## Structure
- Package `apsk_metric_pkg` holds:
  - the mode encoding,
  - the `nsym_of(mode)` function,
  - `MAX_METRIC`,
  - the erasure pattern,
  - the Q-format width constants.
- Sub-module `apsk_metric_lane`: one pipelined lane, a 2-stage datapath with enable, instantiated LANES times by generate.
- The top level holds the FSM, group counter, mask/last pipeline and handshake.

## Test plan
- **Basic metrics.** Mode 3, LANES=8, h=1024, u=(1024,0), LUT point0=(1024,0), point1=(0,0), point2=(−1024,0). Expected: group 0 at t+3 carries metrics 0, 1024, 4096. Eight groups follow, and `out_last` is set only on group 7.
- **Saturation.** u=(130048,0), h=1024, s=(−130048,0). Expected: metric 131071, with no wrap to a small value.
- **Erasure and mode 0.** Erasure point (0x3FFFF,0x3FFFF) gives 131071. Mode 0 gives one group with mask 0x0F, lanes 4–7 = 131071 and `out_last`=1.
- **Backpressure.** Hold `out_ready`=0 for 5 cycles mid-sample. Expected: outputs stable, `lut_addr` frozen, `in_ready`=0, and no group lost or duplicated after release.
- **Back-to-back samples.** Two samples with `in_valid` held high. Expected: the second is accepted on the last-issue cycle of the first, with no idle cycle between group 7 and the new group 0.
- **Reset mid-sample.** Assert `rst` during group 3. Expected: next cycle `out_valid`=0, `out_metric`=0, `in_ready`=1, and a fresh sample restarts at group 0.
